// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Bundle between the datapath and the 7-segment scan driver.
//   master : datapath side, drives value/dp_in/load, observes display pins.
//   slave  : driver side, consumes value/dp_in/load, drives the display pins.
//   value      [4*NUM_DIGITS] packed hex, nibble i -> digit i (digit 0 = LSB)
//   dp_in      [NUM_DIGITS]   decimal-point request per digit
//   load                      one-cycle capture strobe
//   a..g, dp                  active-high segment / decimal-point drives
//   digit      [NUM_DIGITS]   one-hot digit enable
//   frame_tick                pulse on first cycle of digit 0 of a new frame
//   pending                   a loaded value is waiting for a frame boundary
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    a, b, c, d, e, f, g;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit;
  logic                    frame_tick;
  logic                    pending;

  modport master (
    output value, dp_in, load,
    input  a, b, c, d, e, f, g, dp, digit, frame_tick, pending
  );

  modport slave (
    input  value, dp_in, load,
    output a, b, c, d, e, f, g, dp, digit, frame_tick, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed multi-digit hex 7-segment driver. Scans one digit per
//   REFRESH_DIV clocks; values are double-buffered and swapped in only at
//   the frame wrap so a frame never shows a torn value.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seg7_scan_driver_if.slave (value/dp_in/load in, display pins out)
// Parameters
//   NUM_DIGITS  1..8, REFRESH_DIV >= 2 (cycles each digit stays lit)
// Build option
//   SEG7_LZ_BLANK_EN : blank leading-zero digits (digit 0 never blanked)
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_driver_if.slave    bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   pval, aval;
  logic [NUM_DIGITS-1:0]        pdp, adp;
  logic                         pend;
  logic                         swap_q;   // active buffer just swapped, not yet on pins
  logic                         wrap_q;   // idx wrapped last edge
  logic                         tick_q;
  logic [6:0]                   seg_q;    // {a,b,c,d,e,f,g}
  logic                         dp_q;
  logic [NUM_DIGITS-1:0]        dig_q;

  logic                         tc, wrap;
  logic [NUM_DIGITS-1:0]        blank;
  logic [NUM_DIGITS-1:0]        dig_n;
  logic [6:0]                   seg_n;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  assign tc   = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap = tc && (idx == IW'(NUM_DIGITS - 1));

  // Leading-zero run from the top digit down; digit 0 is never blanked.
  always_comb begin
    blank = '0;
`ifdef SEG7_LZ_BLANK_EN
    begin : lz
      logic zrun;
      zrun = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        zrun     = zrun & (aval[i] == 4'h0);
        blank[i] = zrun;
      end
    end
`endif
  end

  always_comb begin
    dig_n      = '0;
    dig_n[idx] = 1'b1;
    seg_n      = blank[idx] ? 7'b0 : hex7(aval[idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      pval   <= '0;
      pdp    <= '0;
      aval   <= '0;
      adp    <= '0;
      pend   <= 1'b0;
      swap_q <= 1'b0;
      wrap_q <= 1'b0;
      tick_q <= 1'b0;
      seg_q  <= '0;
      dp_q   <= 1'b0;
      dig_q  <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc) idx <= wrap ? '0 : idx + IW'(1);
      // Swap uses the pre-edge pending buffer, so a coincident load
      // lands in pval for the following frame.
      if (wrap && pend) begin
        aval <= pval;
        adp  <= pdp;
      end
      if (bus.load) begin
        pval <= bus.value;
        pdp  <= bus.dp_in;
      end
      pend   <= bus.load | (pend & ~wrap);
      swap_q <= wrap & pend;
      wrap_q <= wrap;
      tick_q <= wrap_q;
      seg_q  <= seg_n;
      dp_q   <= adp[idx];
      dig_q  <= dig_n;
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit      = dig_q;
  assign bus.frame_tick = tick_q;
  // Held through the swap cycle so it drops exactly when the new value hits the pins.
  assign bus.pending    = pend | swap_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         SA = 7'b1110111, SF = 7'b1000111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   k = 0;       // edges since reset release

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] seg;
  assign seg = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wait_to(input int target);
    while (k < target) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_dig;
    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    repeat (3) step();
    checks++;
    if ({seg, bus.dp, bus.digit, bus.frame_tick, bus.pending} !== 14'b0) begin
      errors++;
      $display("FAIL reset_outputs got seg=%b dp=%b digit=%b tick=%b pend=%b exp all 0",
               seg, bus.dp, bus.digit, bus.frame_tick, bus.pending);
    end
    rst = 1'b0; k = 0;
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_dig = 4'b0001 << (((i - 1) / 4) % 4);
      checks++;
      if (bus.digit !== exp_dig || seg !== S0) begin
        errors++;
        $display("FAIL scan_k%0d got digit=%b seg=%b exp digit=%b seg=%b",
                 k, bus.digit, seg, exp_dig, S0);
      end
      checks++;
      if (bus.frame_tick !== (i == 17)) begin
        errors++;
        $display("FAIL frame_tick_k%0d got %b exp %b", k, bus.frame_tick, (i == 17));
      end
    end
    step();
    checks++;
    if (bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL frame_tick_k18 got %b exp 0", bus.frame_tick);
    end
  endtask

  task automatic test_load();
    // k == 18: mid-frame load
    bus.value = 16'h1A3F; bus.dp_in = 4'b0100; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (k <= 32) begin
      checks++;
      if (bus.pending !== 1'b1) begin
        errors++;
        $display("FAIL pending_hold_k%0d got %b exp 1", k, bus.pending);
      end
      step();
    end
    // k == 33: new frame shows 1A3F
    checks++;
    if (bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL pending_clear got %b exp 0", bus.pending);
    end
    checks++;
    if (seg !== SF || bus.dp !== 1'b0 || bus.digit !== 4'b0001) begin
      errors++;
      $display("FAIL load_d0 got seg=%b dp=%b digit=%b exp %b 0 0001", seg, bus.dp, bus.digit, SF);
    end
    wait_to(37);
    checks++;
    if (seg !== S3 || bus.dp !== 1'b0 || bus.digit !== 4'b0010) begin
      errors++;
      $display("FAIL load_d1 got seg=%b dp=%b digit=%b exp %b 0 0010", seg, bus.dp, bus.digit, S3);
    end
    wait_to(41);
    checks++;
    if (seg !== SA || bus.dp !== 1'b1 || bus.digit !== 4'b0100) begin
      errors++;
      $display("FAIL load_d2 got seg=%b dp=%b digit=%b exp %b 1 0100", seg, bus.dp, bus.digit, SA);
    end
    wait_to(45);
    checks++;
    if (seg !== S1 || bus.dp !== 1'b0 || bus.digit !== 4'b1000) begin
      errors++;
      $display("FAIL load_d3 got seg=%b dp=%b digit=%b exp %b 0 1000", seg, bus.dp, bus.digit, S1);
    end
  endtask

  task automatic test_two_loads();
    // k == 45: two loads before the wrap at edge 48
    bus.value = 16'h1111; bus.dp_in = '0; bus.load = 1'b1;
    step();
    bus.value = 16'h2222;
    step();
    bus.load = 1'b0;
    wait_to(49);
    while (k <= 64) begin
      checks++;
      if (seg !== S2) begin
        errors++;
        $display("FAIL latest_wins_k%0d got %b exp %b", k, seg, S2);
      end
      step();
    end
  endtask

  task automatic test_load_on_wrap();
    // k == 65: queue 3333, then load 4444 on wrap edge 80
    bus.value = 16'h3333; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_to(79);
    bus.value = 16'h4444; bus.load = 1'b1;
    step();                       // k == 80, load on the wrap edge
    bus.load = 1'b0;
    checks++;
    if (bus.pending !== 1'b1) begin
      errors++;
      $display("FAIL wrap_load_pend_k80 got %b exp 1", bus.pending);
    end
    step();                       // k == 81
    checks++;
    if (seg !== S3 || bus.pending !== 1'b1) begin
      errors++;
      $display("FAIL wrap_load_k81 got seg=%b pend=%b exp %b 1", seg, bus.pending, S3);
    end
    wait_to(93);
    checks++;
    if (seg !== S3 || bus.digit !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_load_k93 got seg=%b digit=%b exp %b 1000", seg, bus.digit, S3);
    end
    wait_to(97);
    checks++;
    if (seg !== S4 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load_k97 got seg=%b pend=%b exp %b 0", seg, bus.pending, S4);
    end
  endtask

  task automatic test_reset_pending();
    // k == 97: queue 5555 then reset while idx == 2 (edges 104..107)
    bus.value = 16'h5555; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_to(105);
    rst = 1'b1;
    bus.load = 1'b1;              // reset must override a load
    step();
    bus.load = 1'b0;
    checks++;
    if ({seg, bus.dp, bus.digit, bus.frame_tick, bus.pending} !== 14'b0) begin
      errors++;
      $display("FAIL rst_pend_outputs got seg=%b digit=%b pend=%b exp all 0",
               seg, bus.digit, bus.pending);
    end
    rst = 1'b0; k = 0;
    step();
    checks++;
    if (seg !== S0 || bus.digit !== 4'b0001 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart got seg=%b digit=%b pend=%b exp %b 0001 0",
               seg, bus.digit, bus.pending, S0);
    end
    wait_to(17);
    checks++;
    if (seg !== S0 || bus.digit !== 4'b0001 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard got seg=%b digit=%b pend=%b exp %b 0001 0",
               seg, bus.digit, bus.pending, S0);
    end
  endtask

  task automatic test_blank();
    logic [6:0] hi_exp;
`ifdef SEG7_LZ_BLANK_EN
    hi_exp = 7'b0;
`else
    hi_exp = S0;
`endif
    wait_to(20);
    bus.value = 16'h0050; bus.dp_in = '0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_to(33);
    checks++;
    if (seg !== S0 || bus.digit !== 4'b0001) begin
      errors++;
      $display("FAIL lz_d0 got seg=%b digit=%b exp %b 0001", seg, bus.digit, S0);
    end
    wait_to(37);
    checks++;
    if (seg !== S5) begin
      errors++;
      $display("FAIL lz_d1 got %b exp %b", seg, S5);
    end
    wait_to(41);
    checks++;
    if (seg !== hi_exp || bus.digit !== 4'b0100) begin
      errors++;
      $display("FAIL lz_d2 got seg=%b digit=%b exp %b 0100", seg, bus.digit, hi_exp);
    end
    wait_to(45);
    checks++;
    if (seg !== hi_exp || bus.digit !== 4'b1000) begin
      errors++;
      $display("FAIL lz_d3 got seg=%b digit=%b exp %b 1000", seg, bus.digit, hi_exp);
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    test_reset();
    test_load();
    test_two_loads();
    test_load_on_wrap();
    test_reset_pending();
    test_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed multi-digit 7-segment display driver, the clocked successor of the single-digit `sd` hex decoder. It holds a packed hex value for `NUM_DIGITS` digits and scans one digit at a time at a programmable refresh rate. It decodes each nibble to segments a–g plus dp. New values are double-buffered and take effect only at a frame boundary, so the display never shows a torn value. The block sits between the datapath and the board's common-bus digit/segment pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; legal range 1–8.
- `REFRESH_DIV`, default 1000: clock cycles each digit stays lit; minimum 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; one clock domain, synchronous, active-high.
- `value`  in  4*NUM_DIGITS  packed hex value; nibble i drives digit i, and digit 0 is the least significant.
- `dp_in`  in  NUM_DIGITS  decimal-point request per digit.
- `load`  in  1  single-cycle strobe that captures `value`/`dp_in` into the pending buffer.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  out  1 each  segment drives, active-high.
- `dp`  out  1  decimal point for the currently lit digit, active-high.
- `digit`  out  NUM_DIGITS  one-hot digit enable, active-high.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.
- `pending`  out  1  high while a loaded value is waiting for the next frame boundary.

## Operation
- The prescaler counts 0..REFRESH_DIV-1. Its terminal count (`tc`) advances the scan index `idx`.
- `idx` runs 0..NUM_DIGITS-1 and wraps to 0. The wrap cycle is `tc` with `idx`=NUM_DIGITS-1.
- Storage consists of a pending buffer (`pval`/`pdp`), an active buffer (`aval`/`adp`) and a `pending` flag.
- `load`=1 copies `value`/`dp_in` into the pending buffer and sets `pending`.
  - A load while already pending overwrites the buffer; the latest value wins.
- On the wrap edge with `pending`=1:
  - The pre-edge pending buffer is copied into the active buffer.
  - `pending` clears, unless `load` is also high that cycle.
- Simultaneous `load` and wrap:
  - The active buffer takes the old pending contents, if any.
  - The new load goes into the pending buffer and `pending`=1.
  - The new value is shown on the next frame.
- Decoding is standard hex, with segments in order abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- `dp` = `adp[idx]`. `digit` = one-hot of `idx`.
- With NUM_DIGITS=1 every `tc` is a wrap, so `frame_tick` pulses every REFRESH_DIV cycles.

## Timing
- Reset values on the first edge with `rst`=1:
  - prescaler=0, idx=0, aval=0, adp=0, pbuf=0, `pending`=0.
  - All outputs 0: segments, `dp`, `digit`, `frame_tick`.
  - `rst` overrides `load` and any in-progress frame; a pending value is discarded.
- Segment, `dp` and `digit` outputs are registered and lag `idx`/`aval` by 1 cycle.
  - The first edge after `rst` falls gives `digit`=…0001 and segments=1111110.
- Digit 0 is lit from cycle 1 through cycle REFRESH_DIV after reset release. `digit` changes every REFRESH_DIV cycles.
- `frame_tick` is registered. It is high for exactly the first cycle that `digit` shows digit 0 of a new frame, not after reset.
- Load-to-display latency:
  - Minimum 2 cycles, when the load lands on the wrap cycle's predecessor.
  - Maximum NUM_DIGITS*REFRESH_DIV+1 cycles.
- `pending` rises 1 cycle after `load` and falls in the same cycle the new value reaches the outputs.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digit i > 0 outputs segments 0000000 when nibbles NUM_DIGITS-1..i of `aval` are all zero.
  - Digit 0 is never blanked. `digit` and `dp` are unaffected.
  - Blanking is computed from `aval` and has the same 1-cycle output latency.
- Not defined: every digit is decoded; zeros show 1111110.

## Test plan
- Reset with NUM_DIGITS=4, REFRESH_DIV=4:
  - `rst` high for 3 cycles → all outputs 0.
  - After release: `digit`=0001 and segments 1111110 for 4 cycles, then 0010, 0100, 1000, 0001.
  - `frame_tick` pulses once on that 0001.
- Load hex 16'h1A3F, dp_in=4'b0100 mid-frame:
  - `pending`=1 until the wrap.
  - Next frame shows digit0=1000111 (F), digit1=1111001 (3), digit2=1110111 (A) with dp=1, digit3=0110000 (1).
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is displayed; 1111 never appears.
- Load asserted on the wrap cycle with a prior value pending → the prior value is shown this frame, the new one next frame, and `pending` stays 1 across the wrap.
- `rst` pulsed while `pending`=1 at idx=2 → outputs 0, the pending value is discarded, and the scan restarts at digit 0 showing 0.
- With `SEG7_LZ_BLANK_EN`, load 16'h0050:
  - digit3 and digit2 segments are 0000000.
  - digit1=1011011 (5), digit0=1111110 (0).
  - Without the macro, digits 3 and 2 show 1111110.
